// File: rtl/action_executor_if.sv
// Action-code handshake between the ALU (master) and the action executor (slave).
interface action_executor_if;
    logic [15:0] action_in;
    logic        action_valid;
    logic        action_ready;

    modport master (output action_in, output action_valid, input action_ready);
    modport slave  (input action_in, input action_valid, output action_ready);
endinterface

// File: rtl/action_executor.sv
// Executes ALU action codes as timed vehicle motion; tracks lateral position and forward-enable.
//   state   | meaning
//   STOPPED | vehicle halted, waiting for CONTINUE
//   RESTART | restart delay running, velocity_en still low
//   RUN     | moving forward, ready for steering codes
//   SHIFT   | lateral step in progress, handshake blocked
module action_executor #(
    parameter int X_MIN          = 0,
    parameter int X_MAX          = 15,
    parameter int X_INIT         = 7,
    parameter int MOVE_CYCLES    = 4,
    parameter int RESTART_CYCLES = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    action_executor_if.slave         act,
    output logic [3:0]               car_x,
    output logic                     velocity_en,
    output logic                     moving,
    output logic                     reject,
    output logic [15:0]              action_count
);
    localparam int T_MAX = (RESTART_CYCLES > MOVE_CYCLES) ? RESTART_CYCLES : MOVE_CYCLES;
    localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    typedef enum logic [1:0] {STOPPED, RESTART, RUN, SHIFT} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            dir_right_q, dir_right_d;
    logic [3:0]      car_x_d;
    logic            reject_d;
    logic            ready_q;
    logic            accept;
    logic            code_stop, code_left, code_right, code_cont;

    assign act.action_ready = ready_q;
    assign accept     = act.action_valid && ready_q;
    assign code_stop  = (act.action_in == 16'd0);
    assign code_left  = (act.action_in == 16'd1);
    assign code_right = (act.action_in == 16'd2);
    assign code_cont  = (act.action_in == 16'd3);

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        dir_right_d = dir_right_q;
        car_x_d     = car_x;
        reject_d    = 1'b0;
        case (state_q)
            STOPPED: begin
                if (accept) begin
                    if (code_cont) begin
                        state_d = RESTART;
                        timer_d = TW'(RESTART_CYCLES - 1);
                    end else if (!code_stop) begin
                        reject_d = 1'b1;
                    end
                end
            end
            RESTART: begin
                // STOP wins over timer expiry on the same edge
                if (accept && code_stop) begin
                    state_d = STOPPED;
                end else begin
                    if (accept && !code_cont) reject_d = 1'b1;
                    if (timer_q == '0) state_d = RUN;
                    else               timer_d = timer_q - 1'b1;
                end
            end
            RUN: begin
                if (accept) begin
                    if (code_stop) begin
                        state_d = STOPPED;
                    end else if (code_left) begin
                        if (car_x == 4'(X_MIN)) begin
                            reject_d = 1'b1;
                        end else begin
                            state_d     = SHIFT;
                            dir_right_d = 1'b0;
                            timer_d     = TW'(MOVE_CYCLES - 1);
                        end
                    end else if (code_right) begin
                        if (car_x == 4'(X_MAX)) begin
                            reject_d = 1'b1;
                        end else begin
                            state_d     = SHIFT;
                            dir_right_d = 1'b1;
                            timer_d     = TW'(MOVE_CYCLES - 1);
                        end
                    end else if (!code_cont) begin
                        reject_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (timer_q == '0) begin
                    car_x_d = dir_right_q ? car_x + 4'd1 : car_x - 4'd1;
                    state_d = RUN;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = STOPPED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= STOPPED;
            timer_q      <= '0;
            dir_right_q  <= 1'b0;
            car_x        <= 4'(X_INIT);
            velocity_en  <= 1'b0;
            moving       <= 1'b0;
            ready_q      <= 1'b1;
            reject       <= 1'b0;
            action_count <= 16'd0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            dir_right_q  <= dir_right_d;
            car_x        <= car_x_d;
            velocity_en  <= (state_d == RUN) || (state_d == SHIFT);
            moving       <= (state_d == SHIFT);
            ready_q      <= (state_d != SHIFT);
            reject       <= reject_d;
            if (accept) action_count <= action_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_action_executor.sv
// Self-checking bench for action_executor against a deadline-based behavioural model.
module tb_action_executor;
    localparam int X_MIN   = 0;
    localparam int X_MAX   = 15;
    localparam int X_INIT  = 7;
    localparam int MOVE    = 4;
    localparam int RESTART = 8;
    localparam logic [23:0] RESET_VEC = {4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  car_x;
    logic        velocity_en, moving, reject;
    logic [15:0] action_count;

    always #5 clk = ~clk;

    action_executor_if act_if();

    action_executor #(
        .X_MIN(X_MIN), .X_MAX(X_MAX), .X_INIT(X_INIT),
        .MOVE_CYCLES(MOVE), .RESTART_CYCLES(RESTART)
    ) dut (
        .clk(clk), .rst_n(rst_n), .act(act_if),
        .car_x(car_x), .velocity_en(velocity_en), .moving(moving),
        .reject(reject), .action_count(action_count)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: motion tracked as absolute edge deadlines rather than countdowns.
    longint cyc = 0;
    longint run_at, shift_end;
    int     m_x, m_count, m_dir;
    bit     m_vel, m_moving, m_reject;

    task automatic model_reset();
        run_at = -1; shift_end = -1;
        m_x = X_INIT; m_count = 0; m_dir = 0;
        m_vel = 0; m_moving = 0; m_reject = 0;
    endtask

    task automatic model_edge(input bit v, input logic [15:0] code);
        int nd;
        m_reject = 0;
        if (m_moving) begin
            if (cyc == shift_end) begin
                m_x = m_x + m_dir;
                m_moving = 0;
            end
        end else begin
            if (v) begin
                m_count = (m_count + 1) % 65536;
                if (code > 16'd3) begin
                    m_reject = 1;
                end else if (m_vel) begin
                    if (code == 16'd0) m_vel = 0;
                    else if (code != 16'd3) begin
                        nd = (code == 16'd1) ? -1 : 1;
                        if (m_x + nd < X_MIN || m_x + nd > X_MAX) m_reject = 1;
                        else begin
                            m_moving = 1; m_dir = nd; shift_end = cyc + MOVE;
                        end
                    end
                end else if (run_at >= 0) begin
                    if (code == 16'd0) run_at = -1;
                    else if (code != 16'd3) m_reject = 1;
                end else begin
                    if (code == 16'd3) run_at = cyc + RESTART;
                    else if (code != 16'd0) m_reject = 1;
                end
            end
            if (run_at == cyc) begin
                m_vel = 1; run_at = -1;
            end
        end
    endtask

    function automatic logic [23:0] exp_v();
        return {4'(m_x), m_vel, m_moving, !m_moving, m_reject, 16'(m_count)};
    endfunction

    function automatic logic [23:0] obs();
        return {car_x, velocity_en, moving, act_if.action_ready, reject, action_count};
    endfunction

    task automatic drive(input bit v, input logic [15:0] code);
        act_if.action_valid = v;
        act_if.action_in    = code;
        @(posedge clk);
        cyc++;
        model_edge(v, code);
        #1;
    endtask

    task automatic test_reset();
        act_if.action_valid = 1'b0;
        act_if.action_in    = 16'd0;
        rst_n = 1'b0;
        model_reset();
        #22;
        checks++;
        if (obs() !== RESET_VEC) begin
            errors++; $display("FAIL reset_state: got %h want %h", obs(), RESET_VEC);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 16'd0);
        checks++;
        if (obs() !== exp_v()) begin
            errors++; $display("FAIL reset_idle: got %h want %h", obs(), exp_v());
        end
    endtask

    task automatic test_restart();
        drive(1, 16'd3);
        for (int k = 1; k <= 10; k++) begin
            checks++;
            if (obs() !== exp_v()) begin
                errors++; $display("FAIL restart_model k=%0d: got %h want %h", k, obs(), exp_v());
            end
            checks++;
            if (velocity_en !== (k > RESTART)) begin
                errors++; $display("FAIL restart_timing k=%0d: got %b want %b", k, velocity_en, k > RESTART);
            end
            drive(0, 16'd0);
        end
    endtask

    task automatic test_shift();
        drive(1, 16'd1);
        checks++;
        if (obs() !== exp_v() || moving !== 1'b1 || act_if.action_ready !== 1'b0) begin
            errors++; $display("FAIL shift_start: got %h want %h", obs(), exp_v());
        end
        for (int k = 1; k <= MOVE; k++) begin
            drive(1, 16'd0);
            checks++;
            if (obs() !== exp_v()) begin
                errors++; $display("FAIL shift_hold_stop k=%0d: got %h want %h", k, obs(), exp_v());
            end
        end
        checks++;
        if (car_x !== 4'd6 || moving !== 1'b0 || act_if.action_ready !== 1'b1) begin
            errors++; $display("FAIL shift_done: got x=%0d mv=%b rdy=%b want x=6 mv=0 rdy=1",
                               car_x, moving, act_if.action_ready);
        end
        drive(1, 16'd0);
        drive(0, 16'd0);
        checks++;
        if (obs() !== exp_v() || velocity_en !== 1'b0) begin
            errors++; $display("FAIL shift_then_stop: got %h want %h", obs(), exp_v());
        end
    endtask

    task automatic test_boundary();
        drive(1, 16'd3);
        repeat (RESTART) drive(0, 16'd0);
        for (int k = 0; k < 60; k++) begin
            drive(1, 16'd2);
            checks++;
            if (obs() !== exp_v()) begin
                errors++; $display("FAIL boundary_right k=%0d: got %h want %h", k, obs(), exp_v());
            end
        end
        drive(0, 16'd0);
        checks++;
        if (car_x !== 4'd15 || velocity_en !== 1'b1 || reject !== 1'b0) begin
            errors++; $display("FAIL boundary_hold: got x=%0d vel=%b rej=%b want x=15 vel=1 rej=0",
                               car_x, velocity_en, reject);
        end
    endtask

    task automatic test_restart_abort();
        drive(1, 16'd0);
        drive(1, 16'd3);
        drive(0, 16'd0);
        drive(1, 16'd0);
        for (int k = 0; k < 12; k++) begin
            drive(0, 16'd0);
            checks++;
            if (obs() !== exp_v() || velocity_en !== 1'b0) begin
                errors++; $display("FAIL restart_abort k=%0d: got %h want %h", k, obs(), exp_v());
            end
        end
        drive(1, 16'd3);
        for (int k = 1; k <= 9; k++) begin
            checks++;
            if (obs() !== exp_v() || velocity_en !== (k > RESTART)) begin
                errors++; $display("FAIL restart_again k=%0d: got %h want %h", k, obs(), exp_v());
            end
            drive(0, 16'd0);
        end
    endtask

    task automatic test_illegal();
        drive(1, 16'h0007);
        checks++;
        if (obs() !== exp_v() || reject !== 1'b1) begin
            errors++; $display("FAIL illegal_run: got %h want %h", obs(), exp_v());
        end
        drive(1, 16'd0);
        drive(1, 16'h0007);
        checks++;
        if (obs() !== exp_v() || reject !== 1'b1) begin
            errors++; $display("FAIL illegal_stopped: got %h want %h", obs(), exp_v());
        end
        drive(1, 16'd1);
        checks++;
        if (obs() !== exp_v() || reject !== 1'b1) begin
            errors++; $display("FAIL left_stopped: got %h want %h", obs(), exp_v());
        end
        drive(0, 16'd0);
        checks++;
        if (obs() !== exp_v() || reject !== 1'b0) begin
            errors++; $display("FAIL reject_single: got %h want %h", obs(), exp_v());
        end
    endtask

    task automatic test_random();
        bit          v = 0;
        logic [15:0] code = 16'd0;
        int          r;
        for (int k = 0; k < 800; k++) begin
            if (!(v && m_moving)) begin
                v = ($urandom_range(0, 99) < 40);
                r = $urandom_range(0, 99);
                if (r < 8)       code = 16'd0;
                else if (r < 33) code = 16'd1;
                else if (r < 58) code = 16'd2;
                else if (r < 92) code = 16'd3;
                else             code = 16'd4 + 16'($urandom_range(0, 65000));
            end
            drive(v, code);
            checks++;
            if (obs() !== exp_v()) begin
                errors++; $display("FAIL random k=%0d code=%h: got %h want %h", k, code, obs(), exp_v());
            end
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 8; k++) drive(1, 16'd0);
        drive(1, 16'd3);
        repeat (RESTART) drive(0, 16'd0);
        drive(1, (m_x > X_MIN) ? 16'd1 : 16'd2);
        drive(0, 16'd0);
        checks++;
        if (obs() !== exp_v() || moving !== 1'b1) begin
            errors++; $display("FAIL pre_reset_shift: got %h want %h", obs(), exp_v());
        end
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (obs() !== RESET_VEC) begin
            errors++; $display("FAIL async_reset: got %h want %h", obs(), RESET_VEC);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 16'd0);
        checks++;
        if (obs() !== exp_v()) begin
            errors++; $display("FAIL post_reset: got %h want %h", obs(), exp_v());
        end
    endtask

    task automatic test_wrap();
        repeat (65535) drive(1, 16'h0007);
        checks++;
        if (action_count !== 16'hFFFF || obs() !== exp_v()) begin
            errors++; $display("FAIL count_ffff: got %h want %h", obs(), exp_v());
        end
        drive(1, 16'h0007);
        checks++;
        if (action_count !== 16'h0000 || obs() !== exp_v()) begin
            errors++; $display("FAIL count_wrap: got %h want %h", obs(), exp_v());
        end
        drive(0, 16'd0);
    endtask

    initial begin
        test_reset();
        test_restart();
        test_shift();
        test_boundary();
        test_restart_abort();
        test_illegal();
        test_random();
        test_async_reset();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
